// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with configurable field widths,
// round-to-nearest-even, flush-to-zero and valid/ready backpressure.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_res,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int EW2     = EXP_W + 2;
  localparam int PW      = 2 * MAN_W + 2;
  localparam int BIAS    = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_MAX = 2 ** EXP_W - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;

  // Stage 1 registers
  logic                 v1_q;
  logic                 sign1_q, sign1_d;
  logic [EW2-1:0]       exp1_q, exp1_d;
  logic [MAN_W:0]       ma1_q, ma1_d;
  logic [MAN_W:0]       mb1_q, mb1_d;
  logic                 spec1_q, spec1_d;
  logic [W-1:0]         sres1_q, sres1_d;
  logic [3:0]           sflg1_q, sflg1_d;
  logic [TAG_W-1:0]     tag1_q;

  // Stage 2 registers
  logic                 v2_q;
  logic                 sign2_q;
  logic [EW2-1:0]       exp2_q;
  logic [PW-1:0]        prod2_q, prod2_d;
  logic                 spec2_q;
  logic [W-1:0]         sres2_q;
  logic [3:0]           sflg2_q;
  logic [TAG_W-1:0]     tag2_q;

  // Stage 3 (output) registers
  logic                 out_valid_q;
  logic [W-1:0]         out_res_q, out_res_d;
  logic [TAG_W-1:0]     out_tag_q;
  logic [3:0]           out_flags_q, out_flags_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign out_flags = out_flags_q;

  // ---------------- S1: unpack, classify, exponent sum ----------------
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    sa = in_a[W-1];
    sb = in_b[W-1];
    ea = in_a[MAN_W +: EXP_W];
    eb = in_b[MAN_W +: EXP_W];
    fa = in_a[MAN_W-1:0];
    fb = in_b[MAN_W-1:0];

    // Subnormal operands count as zero.
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == {EXP_W{1'b1}}) && (fa == '0);
    b_inf  = (eb == {EXP_W{1'b1}}) && (fb == '0);
    a_nan  = (ea == {EXP_W{1'b1}}) && (fa != '0);
    b_nan  = (eb == {EXP_W{1'b1}}) && (fb != '0);

    sign1_d = sa ^ sb;
    exp1_d  = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS);
    ma1_d   = {1'b1, fa};
    mb1_d   = {1'b1, fb};
    spec1_d = 1'b1;
    sres1_d = '0;
    sflg1_d = 4'b0000;

    if (a_nan || b_nan) begin
      sres1_d = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      sres1_d = QNAN;
      sflg1_d = 4'b1000;
    end else if (a_inf || b_inf) begin
      sres1_d = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      sres1_d = {sign1_d, {(W-1){1'b0}}};
    end else begin
      spec1_d = 1'b0;
    end
  end

  // ---------------- S2: mantissa product ----------------
  assign prod2_d = {{(MAN_W+1){1'b0}}, ma1_q} * {{(MAN_W+1){1'b0}}, mb1_q};

  // ---------------- S3: normalise, round, pack ----------------
  logic                 msb, guard, sticky, rnd, carry, ovf, unf;
  logic [MAN_W-1:0]     frac, frac_o;
  logic [MAN_W:0]       frac_r;
  logic [EW2-1:0]       exp_n;

  always_comb begin
    msb    = prod2_q[PW-1];
    frac   = msb ? prod2_q[PW-2 -: MAN_W] : prod2_q[PW-3 -: MAN_W];
    guard  = msb ? prod2_q[MAN_W] : prod2_q[MAN_W-1];
    sticky = msb ? (|prod2_q[MAN_W-1:0]) : (|prod2_q[MAN_W-2:0]);
    rnd    = guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    carry  = frac_r[MAN_W];
    frac_o = carry ? '0 : frac_r[MAN_W-1:0];
    exp_n  = exp2_q + {{(EW2-1){1'b0}}, msb} + {{(EW2-1){1'b0}}, carry};

    // exp_n is two's complement; the top bit flags a negative exponent.
    ovf = !exp_n[EW2-1] && (exp_n >= EW2'(EXP_MAX));
    unf = exp_n[EW2-1] || (exp_n == '0);

    out_res_d   = {sign2_q, exp_n[EXP_W-1:0], frac_o};
    out_flags_d = {3'b000, guard || sticky};
    if (spec2_q) begin
      out_res_d   = sres2_q;
      out_flags_d = sflg2_q;
    end else if (ovf) begin
      out_res_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_flags_d = 4'b0101;
    end else if (unf) begin
      out_res_d   = {sign2_q, {(W-1){1'b0}}};
      out_flags_d = 4'b0011;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      exp1_q      <= '0;
      ma1_q       <= '0;
      mb1_q       <= '0;
      spec1_q     <= 1'b0;
      sres1_q     <= '0;
      sflg1_q     <= '0;
      tag1_q      <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      exp2_q      <= '0;
      prod2_q     <= '0;
      spec2_q     <= 1'b0;
      sres2_q     <= '0;
      sflg2_q     <= '0;
      tag2_q      <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      sign1_q     <= sign1_d;
      exp1_q      <= exp1_d;
      ma1_q       <= ma1_d;
      mb1_q       <= mb1_d;
      spec1_q     <= spec1_d;
      sres1_q     <= sres1_d;
      sflg1_q     <= sflg1_d;
      tag1_q      <= in_tag;

      v2_q        <= v1_q;
      sign2_q     <= sign1_q;
      exp2_q      <= exp1_q;
      prod2_q     <= prod2_d;
      spec2_q     <= spec1_q;
      sres2_q     <= sres1_q;
      sflg2_q     <= sflg1_q;
      tag2_q      <= tag1_q;

      out_valid_q <= v2_q;
      out_res_q   <= out_res_d;
      out_tag_q   <= tag2_q;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at FP32 defaults: a bit-level reference
// model predicts each accepted op, results are popped in order at the output.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  tag;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic lat_en = 1'b0;
  logic rand_rdy = 1'b0;
  logic stall_prev = 1'b0;
  logic [39:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic [63:0] m, q, rem, half;
    logic an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return {4'b0000, 32'h7FC00000};
    if ((ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, s, 31'h0};
    m = 64'({1'b1, fa}) * 64'({1'b1, fb});
    e = ea + eb - 127;
    if (m[47]) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = m >> sh;
    rem  = m & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, e[7:0], q[22:0]};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: sampled mid-cycle, inputs change just after the rising edge.
  always @(negedge clk) begin
    logic [35:0] m;
    exp_t e;
    if (!rst) begin
      if (stall_prev) check("stable", 64'({out_res, out_flags, out_tag}), 64'(held));
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        m = model(in_a, in_b);
        sb.push_back('{res: m[31:0], flags: m[35:32], tag: in_tag, cyc: 32'(cyc)});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("res", 64'(out_res), 64'(e.res));
          check("flags", 64'(out_flags), 64'(e.flags));
          check("tag", 64'(out_tag), 64'(e.tag));
          if (lat_en) check("latency", 64'(cyc - int'(e.cyc)), 64'd3);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_res, out_flags, out_tag};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    logic acc;
    int n;
    in_a = a;
    in_b = b;
    in_tag = t;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ta [12];
    logic [31:0] tb [12];
    logic saw;
    ta = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h80000000,
           32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h00000000, 32'h007FFFFF, 32'hC0000000};
    tb = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h3F000000, 32'h3F800000,
           32'h00000000, 32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F800000, 32'h3FFFFFFF};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, back-to-back, latency checked.
    lat_en = 1'b1;
    for (int i = 0; i < 12; i++) send(ta[i], tb[i], 4'(i));
    drain();

    // Random normal-range and fully random operands.
    for (int i = 0; i < 30; i++)
      send({1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)},
           {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)}, 4'(i));
    for (int i = 0; i < 20; i++) send($urandom, $urandom, 4'(i));
    drain();
    lat_en = 1'b0;

    // Explicit stall: pipeline must freeze and hold in_ready low.
    out_ready = 1'b0;
    send(32'h40400000, 32'h40400000, 4'hA);
    send(32'hBF800000, 32'h3E800000, 4'hB);
    send(32'h3F800000, 32'h3F800000, 4'hC);
    repeat (5) @(posedge clk);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain();

    // Random backpressure streaming.
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      send({1'b0, 8'($urandom_range(100, 150)), 23'($urandom)}, {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)}, 4'(i));
    for (int i = 0; i < 24; i++) send($urandom, {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 4'(i + 8));
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset with three operations in flight.
    send(32'h3FC00000, 32'h40000000, 4'h1);
    send(32'h40000000, 32'h40000000, 4'h2);
    send(32'h40400000, 32'h40000000, 4'h3);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("no_stale", 64'(saw), 64'd0);
    lat_en = 1'b1;
    send(32'h3F800001, 32'h3FC00000, 4'h9);
    drain();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
